// File: rtl/issue_ctrl.sv
// Decode-stage issue sequencer: register scoreboard, RAW stalls and redirect flush.
// Optional ISSUE_CTRL_WB_BYPASS_EN lets a source clear in its writeback cycle.
module issue_ctrl #(
    parameter int AWIDTH       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid_i,
    input  logic [4:0]           dec_rs1_i,
    input  logic [4:0]           dec_rs2_i,
    input  logic [4:0]           dec_rd_i,
    input  logic                 dec_uses_rs1_i,
    input  logic                 dec_uses_rs2_i,
    input  logic                 dec_writes_rd_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_rd_i,
    input  logic                 redirect_i,
    input  logic [AWIDTH-1:0]    redirect_pc_i,
    output logic                 issue_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 pc_sel_o,
    output logic [AWIDTH-1:0]    pc_redirect_o,
    output logic [31:0]          busy_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 state;
    logic [FCW-1:0]         flush_cnt;
    logic [31:0]            busy;
    logic [CNT_WIDTH-1:0]   stall_cnt;

    logic [31:0]            wb_clr;
    logic [31:0]            rd_set;
    logic [31:0]            busy_chk;
    logic [31:0]            busy_nxt;
    logic                   hazard;
    logic                   flush;
    logic                   stall;
    logic                   issue;

    always_comb begin
        wb_clr = '0;
        if (wb_valid_i) wb_clr[wb_rd_i] = 1'b1;
    end

`ifdef ISSUE_CTRL_WB_BYPASS_EN
    // regfile writes through, so a retiring reg is already readable
    assign busy_chk = busy & ~wb_clr;
`else
    assign busy_chk = busy;
`endif

    assign hazard = dec_valid_i &
                    ((dec_uses_rs1_i & busy_chk[dec_rs1_i]) |
                     (dec_uses_rs2_i & busy_chk[dec_rs2_i]));

    assign flush = redirect_i | (state == FLUSH);
    assign stall = hazard & ~flush;
    assign issue = dec_valid_i & ~hazard & ~flush;

    always_comb begin
        rd_set = '0;
        if (issue && dec_writes_rd_i && dec_rd_i != 5'd0) rd_set[dec_rd_i] = 1'b1;
    end

    // new writer wins over a same-cycle retire; x0 never tracked
    assign busy_nxt = ((busy & ~wb_clr) | rd_set) & 32'hFFFF_FFFE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (redirect_i) begin
                state     <= FLUSH;
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            end else begin
                unique case (state)
                    FLUSH: begin
                        if (flush_cnt != '0) begin
                            flush_cnt <= flush_cnt - FCW'(1);
                        end else begin
                            state <= RUN;
                        end
                    end
                    default: state <= stall ? STALL : RUN;
                endcase
            end
        end
    end

    assign issue_o       = issue;
    assign stall_o       = stall;
    assign flush_o       = flush;
    assign pc_sel_o      = redirect_i;
    assign pc_redirect_o = redirect_pc_i;
    assign busy_o        = busy;
    assign state_o       = state;
    assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed-vector bench for issue_ctrl: RAW stall, redirect flush, scoreboard corners,
// reset abort and stall-counter saturation (narrow counter).
module tb_issue_ctrl;

    localparam int AW = 32;
    localparam int CW = 4;

`ifdef ISSUE_CTRL_WB_BYPASS_EN
    localparam int SC1 = 1;
`else
    localparam int SC1 = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [4:0]    dec_rd;
    logic          dec_uses_rs1;
    logic          dec_uses_rs2;
    logic          dec_writes_rd;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          issue;
    logic          stall;
    logic          flush;
    logic          pc_sel;
    logic [AW-1:0] pc_redirect;
    logic [31:0]   busy;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    issue_ctrl #(
        .AWIDTH       (AW),
        .FLUSH_CYCLES (2),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dec_valid_i     (dec_valid),
        .dec_rs1_i       (dec_rs1),
        .dec_rs2_i       (dec_rs2),
        .dec_rd_i        (dec_rd),
        .dec_uses_rs1_i  (dec_uses_rs1),
        .dec_uses_rs2_i  (dec_uses_rs2),
        .dec_writes_rd_i (dec_writes_rd),
        .wb_valid_i      (wb_valid),
        .wb_rd_i         (wb_rd),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .issue_o         (issue),
        .stall_o         (stall),
        .flush_o         (flush),
        .pc_sel_o        (pc_sel),
        .pc_redirect_o   (pc_redirect),
        .busy_o          (busy),
        .state_o         (state),
        .stall_cnt_o     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_idle();
        dec_valid     = 1'b0;
        dec_rs1       = 5'd0;
        dec_rs2       = 5'd0;
        dec_rd        = 5'd0;
        dec_uses_rs1  = 1'b0;
        dec_uses_rs2  = 1'b0;
        dec_writes_rd = 1'b0;
    endtask

    task automatic dec_insn(input logic [4:0] rd, input logic wr,
                            input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        dec_valid     = 1'b1;
        dec_rd        = rd;
        dec_writes_rd = wr;
        dec_rs1       = rs1;
        dec_uses_rs1  = u1;
        dec_rs2       = rs2;
        dec_uses_rs2  = u2;
    endtask

    initial begin
        rst         = 1'b1;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_idle();
        tick();
        tick();
        rst = 1'b0;

        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", busy, 32'h0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pcsel", 32'(pc_sel), 32'd0);
        check("rst_issue_idle", 32'(issue), 32'd0);

        // RAW on x5
        dec_insn(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("t1_issue_rd5", 32'(issue), 32'd1);
        tick();
        dec_insn(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        check("t1_stall", 32'(stall), 32'd1);
        check("t1_noissue", 32'(issue), 32'd0);
        check("t1_busy5", busy, 32'h0000_0020);
        tick();
        check("t1_state_stall", 32'(state), 32'd1);
        check("t1_cnt1", 32'(stall_cnt), 32'd1);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
        check("t2_issue_wb", 32'(issue), 32'd1);
        check("t2_nostall_wb", 32'(stall), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("t2_busy6", busy, 32'h0000_0040);
        check("t2_cnt", 32'(stall_cnt), 32'(SC1));
        check("t2_state_run", 32'(state), 32'd0);
`else
        check("t1_stall_wb", 32'(stall), 32'd1);
        check("t1_noissue_wb", 32'(issue), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("t1_busy_clr", busy, 32'h0);
        check("t1_cnt2", 32'(stall_cnt), 32'(SC1));
        #1;
        check("t1_issue_after", 32'(issue), 32'd1);
        check("t1_nostall_after", 32'(stall), 32'd0);
        tick();
        check("t1_busy6", busy, 32'h0000_0040);
        check("t1_state_run", 32'(state), 32'd0);
`endif
        dec_idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        tick();
        wb_valid = 1'b0;
        check("t1_busy_empty", busy, 32'h0);

        // redirect flush; flushed writer must not mark x9
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        dec_insn(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("t3_pcsel", 32'(pc_sel), 32'd1);
        check("t3_pcredir", pc_redirect, 32'h0000_0100);
        check("t3_flush0", 32'(flush), 32'd1);
        check("t3_issue0", 32'(issue), 32'd0);
        check("t3_stall0", 32'(stall), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("t3_state_f1", 32'(state), 32'd2);
        check("t3_flush1", 32'(flush), 32'd1);
        check("t3_issue1", 32'(issue), 32'd0);
        check("t3_pcsel1", 32'(pc_sel), 32'd0);
        tick();
        check("t3_state_f2", 32'(state), 32'd2);
        check("t3_flush2", 32'(flush), 32'd1);
        check("t3_issue2", 32'(issue), 32'd0);
        tick();
        check("t3_state_run", 32'(state), 32'd0);
        check("t3_flush_end", 32'(flush), 32'd0);
        check("t3_busy", busy, 32'h0);
        dec_writes_rd = 1'b0;
        #1;
        check("t3_issue_run", 32'(issue), 32'd1);
        dec_idle();

        // redirect while stalled
        dec_insn(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        dec_insn(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        #1;
        check("t4_stall", 32'(stall), 32'd1);
        tick();
        check("t4_state_stall", 32'(state), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check("t4_flush", 32'(flush), 32'd1);
        check("t4_nostall", 32'(stall), 32'd0);
        check("t4_noissue", 32'(issue), 32'd0);
        check("t4_pcredir", pc_redirect, 32'h0000_0200);
        tick();
        redirect = 1'b0;
        check("t4_state_flush", 32'(state), 32'd2);
        check("t4_busy", busy, 32'h0000_0008);
        check("t4_cnt", 32'(stall_cnt), 32'(SC1 + 1));
        dec_idle();
        tick();
        tick();
        check("t4_state_run", 32'(state), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        tick();
        wb_valid = 1'b0;
        check("t4_busy_clr", busy, 32'h0);

        // x0 handling, same-cycle set/clear, stray writeback
        dec_insn(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("t5_issue_x0", 32'(issue), 32'd1);
        tick();
        check("t5_busy_x0", busy, 32'h0);
        dec_insn(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        check("t5_nostall_x0", 32'(stall), 32'd0);
        check("t5_issue_rs0", 32'(issue), 32'd1);
        tick();
        dec_insn(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        tick();
        check("t5_set_wins", busy, 32'h0000_0080);
        dec_idle();
        wb_rd = 5'd12;
        tick();
        wb_valid = 1'b0;
        check("t5_stray_wb", busy, 32'h0000_0080);
        dec_insn(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        dec_idle();
        check("t5_busy_a0", busy, 32'h0000_00A0);

        // reset aborts a flush
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        check("t6_state_flush", 32'(state), 32'd2);
        check("t6_busy_a0", busy, 32'h0000_00A0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_state_run", 32'(state), 32'd0);
        check("t6_busy", busy, 32'h0);
        check("t6_cnt", 32'(stall_cnt), 32'd0);
        check("t6_flush", 32'(flush), 32'd0);

        // counter saturates at all-ones
        dec_insn(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        dec_insn(5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("t7_cnt_sat", 32'(stall_cnt), 32'd15);
        check("t7_stall", 32'(stall), 32'd1);
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        tick();
        wb_valid = 1'b0;
        check("t7_cnt_hold", 32'(stall_cnt), 32'd15);
        #1;
        check("t7_issue", 32'(issue), 32'd1);
        dec_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
